sample_spi_tx: RTL and testbench

- Downstream neighbour of the datapath control FSM: serialises one processed audio sample per frame to the MCU over SPI.
- FPGA is SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
- The control FSM pulses `load` when a sample is ready and holds its transmit state while `transmit` is high.
- Returns to pause on `transmit` low.

---
 rtl/sample_spi_tx.sv | 122 ++++++++++++
 tb/tb_sample_spi_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_spi_tx.sv
// SPI mode-0 master that serialises one audio sample per frame, MSB first.
// Define SPI_PARITY_EN to append an even-parity bit after the LSB.
module sample_spi_tx #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] sample,
  output logic              transmit,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n
);

`ifdef SPI_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] load_word;
  logic             div_tc;

`ifdef SPI_PARITY_EN
  assign load_word = {sample, ^sample};
`else
  assign load_word = sample;
`endif

  assign div_tc = (div_cnt == DIV_LAST);

  // The same divider times SETUP, each half sclk period, and HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      transmit <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg    <= load_word;
            mosi     <= load_word[NBITS-1];
            cs_n     <= 1'b0;
            transmit <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (div_tc) begin
            div_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == BIT_LAST) begin
              // Last falling edge: mosi keeps the final bit through HOLD.
              state <= HOLD;
            end else begin
              shreg <= {shreg[NBITS-2:0], 1'b0};
              mosi  <= shreg[NBITS-2];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (div_tc) begin
            div_cnt  <= '0;
            state    <= IDLE;
            cs_n     <= 1'b1;
            transmit <= 1'b0;
            done     <= 1'b1;
            mosi     <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cs_n     <= 1'b1;
          transmit <= 1'b0;
          sclk     <= 1'b0;
          mosi     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_spi_tx.sv
// Directed self-checking bench for sample_spi_tx with an MCU-side receiver model.
// Honours SPI_PARITY_EN when the same macro is defined for the build.
module tb_sample_spi_tx;

  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 4;
`ifdef SPI_PARITY_EN
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif
  localparam int TX_LEN = 2 * CLK_DIV + 2 * NB * CLK_DIV;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load = 1'b0;
  logic [DATA_W-1:0] sample = '0;
  logic              transmit, done, sclk, mosi, cs_n;

  int tests_run = 0;
  int tests_failed = 0;

  int cyc, tx_cnt, cs_low_cnt, done_cnt, first_done, last_done, first_tx, last_tx;
  int sclk_hi, mosi_hi, mosi_first;
  int bits0;

  logic [63:0] rx = '0;
  int          rx_bits = 0;

  sample_spi_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .load(load), .sample(sample),
    .transmit(transmit), .done(done), .sclk(sclk), .mosi(mosi), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  // MCU receiver: samples mosi on each rising sclk edge.
  always @(posedge sclk) begin
    rx      <= {rx[62:0], mosi};
    rx_bits <= rx_bits + 1;
  end

  function automatic logic [63:0] exp_frame(input logic [15:0] s);
`ifdef SPI_PARITY_EN
    return {47'b0, s, ^s};
`else
    return {48'b0, s};
`endif
  endfunction

  function automatic logic [63:0] frame_mask(input int n);
    logic [63:0] one;
    one = 64'd1;
    return (one << n) - 64'd1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearCounters();
    cyc = 0; tx_cnt = 0; cs_low_cnt = 0; done_cnt = 0;
    first_done = -1; last_done = -1; first_tx = -1; last_tx = -1;
    sclk_hi = 0; mosi_hi = 0; mosi_first = -1;
    bits0 = rx_bits;
  endtask

  // Drive load for exactly one rising edge, then scramble sample.
  task automatic pulseLoad(input logic [15:0] s);
    load = 1'b1;
    sample = s;
    @(posedge clk);
    #1;
    load = 1'b0;
    sample = 16'($urandom);
  endtask

  task automatic applyStimulus(input logic [15:0] s);
    clearCounters();
    pulseLoad(s);
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (transmit) begin
        tx_cnt++;
        if (first_tx < 0) first_tx = cyc;
        last_tx = cyc;
      end
      if (!cs_n) cs_low_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
        last_done = cyc;
      end
      if (sclk) sclk_hi++;
      if (mosi) mosi_hi++;
      if (cyc == 1) mosi_first = int'(mosi);
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_cs_n", 64'(cs_n), 64'd1);
    checkOutput("rst_transmit", 64'(transmit), 64'd0);
    checkOutput("rst_sclk", 64'(sclk), 64'd0);
    checkOutput("rst_mosi", 64'(mosi), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    reset = 1'b1;

    // Idle for 20 cycles
    clearCounters();
    runCycles(20);
    checkOutput("idle_tx", 64'(tx_cnt), 64'd0);
    checkOutput("idle_cs_low", 64'(cs_low_cnt), 64'd0);
    checkOutput("idle_done", 64'(done_cnt), 64'd0);
    checkOutput("idle_sclk", 64'(sclk_hi), 64'd0);
    checkOutput("idle_mosi", 64'(mosi_hi), 64'd0);

    // Single frame 0xA5C3
    applyStimulus(16'hA5C3);
    runCycles(TX_LEN + 4);
    checkOutput("a5_mosi_first", 64'(mosi_first), 64'd1);
    checkOutput("a5_first_tx", 64'(first_tx), 64'd1);
    checkOutput("a5_tx_cnt", 64'(tx_cnt), 64'(TX_LEN));
    checkOutput("a5_cs_low", 64'(cs_low_cnt), 64'(TX_LEN));
    checkOutput("a5_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("a5_done_at", 64'(first_done), 64'(TX_LEN + 1));
    checkOutput("a5_bits", 64'(rx_bits - bits0), 64'(NB));
    checkOutput("a5_word", rx & frame_mask(NB), exp_frame(16'hA5C3));
    checkOutput("a5_mosi_idle", 64'(mosi), 64'd0);

    // Load while busy is ignored
    applyStimulus(16'h1234);
    runCycles(50);
    pulseLoad(16'hFFFF);
    runCycles(TX_LEN + 10 - 50);
    checkOutput("busy_tx_cnt", 64'(tx_cnt), 64'(TX_LEN));
    checkOutput("busy_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("busy_done_at", 64'(first_done), 64'(TX_LEN + 1));
    checkOutput("busy_bits", 64'(rx_bits - bits0), 64'(NB));
    checkOutput("busy_word", rx & frame_mask(NB), exp_frame(16'h1234));

    // Back-to-back frames with load in the done cycle
    applyStimulus(16'h8001);
    runCycles(TX_LEN + 1);
    checkOutput("b2b_done_now", 64'(done), 64'd1);
    pulseLoad(16'h0F0F);
    runCycles(TX_LEN + 9);
    checkOutput("b2b_done_cnt", 64'(done_cnt), 64'd2);
    checkOutput("b2b_done1_at", 64'(first_done), 64'(TX_LEN + 1));
    checkOutput("b2b_done2_at", 64'(last_done), 64'(2 * (TX_LEN + 1)));
    checkOutput("b2b_cs_low", 64'(cs_low_cnt), 64'(2 * TX_LEN));
    checkOutput("b2b_tx_cnt", 64'(tx_cnt), 64'(2 * TX_LEN));
    checkOutput("b2b_bits", 64'(rx_bits - bits0), 64'(2 * NB));
    checkOutput("b2b_words", rx & frame_mask(2 * NB),
                (exp_frame(16'h8001) << NB) | exp_frame(16'h0F0F));

    // Reset mid-frame
    applyStimulus(16'hFFFF);
    runCycles(39);
    checkOutput("mid_busy", 64'(transmit), 64'd1);
    checkOutput("mid_cs_low", 64'(cs_n), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("mid_rst_cs_n", 64'(cs_n), 64'd1);
    checkOutput("mid_rst_transmit", 64'(transmit), 64'd0);
    checkOutput("mid_rst_sclk", 64'(sclk), 64'd0);
    checkOutput("mid_rst_mosi", 64'(mosi), 64'd0);
    checkOutput("mid_rst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clearCounters();
    runCycles(TX_LEN + 10);
    checkOutput("post_rst_done", 64'(done_cnt), 64'd0);
    checkOutput("post_rst_tx", 64'(tx_cnt), 64'd0);
    checkOutput("post_rst_bits", 64'(rx_bits - bits0), 64'd0);

    // Recovery frame 0x0001
    applyStimulus(16'h0001);
    runCycles(TX_LEN + 4);
    checkOutput("rec_tx_cnt", 64'(tx_cnt), 64'(TX_LEN));
    checkOutput("rec_done_at", 64'(first_done), 64'(TX_LEN + 1));
    checkOutput("rec_bits", 64'(rx_bits - bits0), 64'(NB));
    checkOutput("rec_word", rx & frame_mask(NB), exp_frame(16'h0001));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
